// File: rtl/lcd_rx_decoder.sv
// lcd_rx_decoder: HD44780 4-bit bus receiver rebuilding bytes, cursor, busy window and timing errors.
// Optional 2x16 character line buffer enabled by LCD_RX_LINEBUF_EN.
module lcd_rx_decoder #(
   parameter int FREQ          = 50000000,
   parameter int BUSY_SHORT_US = 37,
   parameter int BUSY_LONG_US  = 1520
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] LCD_D,
   input  logic       LCD_E,
`ifdef LCD_RX_LINEBUF_EN
   input  logic       rd_line,
   input  logic [3:0] rd_col,
   output logic [7:0] rd_char,
`endif
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_rs,
   output logic       ram_we,
   output logic [6:0] ram_addr,
   output logic [7:0] ram_wdata,
   output logic [6:0] cursor,
   output logic       mode4,
   output logic       busy,
   output logic       err_timing
);
   localparam logic [20:0] SHORT_CNT = 21'(FREQ / 1000000 * BUSY_SHORT_US);
   localparam logic [20:0] LONG_CNT  = 21'(FREQ / 1000000 * BUSY_LONG_US);

   typedef enum logic [1:0] {IF8, HI, LO} stateT;
   stateT state, nextState;

   logic        eReg, fall, done, rsErr, busyErr, isLong, incr, hiRs, newRs;
   logic [4:0]  hold;
   logic [3:0]  hiNib;
   logic [7:0]  newByte;
   logic [20:0] busyCnt;

   assign fall    = eReg & ~LCD_E;
   assign mode4   = state != IF8;
   assign busy    = busyCnt != 21'd0;
   // a fall on the edge where the counter reaches zero is not a violation
   assign busyErr = fall && state != LO && busyCnt > 21'd1;
   assign isLong  = !newRs && (newByte == 8'h01 || newByte[7:1] == 7'h01);

   always_ff @(posedge CLK)
      state <= RST ? IF8 : nextState;

   always_comb begin
      nextState = state;
      done      = 1'b0;
      rsErr     = 1'b0;
      newByte   = {hold[3:0], 4'h0};
      newRs     = hold[4];
      if (fall) begin
         case (state)
            IF8: begin
               done      = 1'b1;
               nextState = (!hold[4] && hold[3:0] == 4'h2) ? HI : IF8;
            end
            HI: nextState = LO;
            default: begin
               done      = 1'b1;
               newByte   = {hiNib, hold[3:0]};
               newRs     = hiRs;
               rsErr     = hold[4] != hiRs;
               nextState = HI;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         eReg       <= 1'b0;
         hold       <= 5'h0;
         hiNib      <= 4'h0;
         hiRs       <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= 8'h0;
         byte_rs    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= 7'h0;
         ram_wdata  <= 8'h0;
         cursor     <= 7'h0;
         incr       <= 1'b1;
         busyCnt    <= 21'd0;
         err_timing <= 1'b0;
      end else begin
         eReg       <= LCD_E;
         if (LCD_E) hold <= LCD_D;
         if (fall && state == HI) {hiRs, hiNib} <= hold;
         byte_valid <= done;
         ram_we     <= done & newRs;
         if (done) begin
            byte_data <= newByte;
            byte_rs   <= newRs;
            ram_addr  <= cursor;
            ram_wdata <= newByte;
         end
         if (busyErr || rsErr) err_timing <= 1'b1;
         busyCnt <= done ? (isLong ? LONG_CNT : SHORT_CNT) : (busy ? busyCnt - 21'd1 : 21'd0);
         if (done && !newRs) begin
            if (newByte == 8'h01) begin
               cursor <= 7'h0;
               incr   <= 1'b1;
            end else if (newByte[7:1] == 7'h01) cursor <= 7'h0;
            else if (newByte[7:2] == 6'h01) incr <= newByte[1];
            else if (newByte[7]) cursor <= newByte[6:0];
         end else if (done) cursor <= incr ? cursor + 7'd1 : cursor - 7'd1;
      end
   end

`ifdef LCD_RX_LINEBUF_EN
   logic [7:0] lineBuf [32];
   // line0 = 0x00-0x0F, line1 = 0x40-0x4F; index is {line, column}
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) lineBuf[i] <= 8'h20;
         rd_char <= 8'h0;
      end else begin
         if (ram_we && ram_addr[5:4] == 2'b00) lineBuf[{ram_addr[6], ram_addr[3:0]}] <= ram_wdata;
         rd_char <= lineBuf[{rd_line, rd_col}];
      end
   end
`endif
endmodule

// File: tb/tb_lcd_rx_decoder.sv
// tb_lcd_rx_decoder: directed-vector bench for lcd_rx_decoder (default 50 MHz timing).
module tb_lcd_rx_decoder;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [4:0] LCD_D = 5'h0;
   logic       LCD_E = 1'b0;
   logic       byte_valid, byte_rs, ram_we, mode4, busy, err_timing;
   logic [7:0] byte_data, ram_wdata;
   logic [6:0] ram_addr, cursor;
   int         checks = 0;
   int         errors = 0;
   int         n;
`ifdef LCD_RX_LINEBUF_EN
   logic       rd_line = 1'b0;
   logic [3:0] rd_col = 4'h0;
   logic [7:0] rd_char;
`endif

   lcd_rx_decoder dut (
      .CLK(CLK), .RST(RST), .LCD_D(LCD_D), .LCD_E(LCD_E),
`ifdef LCD_RX_LINEBUF_EN
      .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
`endif
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cursor(cursor), .mode4(mode4), .busy(busy), .err_timing(err_timing)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns on the negedge after the fall edge, where registered results are visible
   task automatic nib(input logic rs, input logic [3:0] d);
      @(negedge CLK);
      LCD_D = {rs, d};
      LCD_E = 1'b1;
      @(negedge CLK);
      LCD_E = 1'b0;
      @(negedge CLK);
   endtask

   task automatic doReset();
      @(negedge CLK);
      RST   = 1'b1;
      LCD_E = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic waitIdle();
      n = 0;
      while (busy && n < 80000) begin
         n++;
         @(negedge CLK);
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      logic [3:0] initNib [4];
      initNib = '{4'h3, 4'h3, 4'h3, 4'h2};
      repeat (3) @(negedge CLK);
      chk("rst_valid", byte_valid, 0);
      chk("rst_cursor", cursor, 0);
      chk("rst_mode4", mode4, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timing, 0);
      chk("rst_we", ram_we, 0);
      RST = 1'b0;
      // 8-bit init sequence, fast strobes (timing errors irrelevant here)
      for (int i = 0; i < 4; i++) begin
         nib(1'b0, initNib[i]);
         chk("if8_valid", byte_valid, 1);
         chk("if8_data", byte_data, {initNib[i], 4'h0});
         chk("if8_rs", byte_rs, 0);
         chk("if8_mode4", mode4, i == 3);
      end
      nib(1'b0, 4'h2);
      chk("hi_no_valid", byte_valid, 0);
      nib(1'b0, 4'hC);
      chk("fs_valid", byte_valid, 1);
      chk("fs_data", byte_data, 8'h2C);
      chk("fs_rs", byte_rs, 0);
      nib(1'b0, 4'h0);
      nib(1'b0, 4'h1);
      chk("clr_data", byte_data, 8'h01);
      chk("clr_cursor", cursor, 0);
      n = 0;
      while (busy && n < 80000) begin
         n++;
         @(negedge CLK);
      end
      chk("clr_busy_len", n, 76000);
      nib(1'b0, 4'h8);
      nib(1'b0, 4'h5);
      chk("ddram_cursor", cursor, 7'h05);
      nib(1'b1, 4'h4);
      nib(1'b1, 4'h1);
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, 7'h05);
      chk("wr_data", ram_wdata, 8'h41);
      chk("wr_rs", byte_rs, 1);
      chk("wr_cursor", cursor, 7'h06);
      @(negedge CLK);
      chk("wr_we_pulse", ram_we, 0);
      nib(1'b0, 4'h0);
      nib(1'b0, 4'h4);
      nib(1'b0, 4'h8);
      nib(1'b0, 4'h0);
      chk("set0_cursor", cursor, 7'h00);
      nib(1'b1, 4'h4);
      nib(1'b1, 4'h2);
      chk("dec_addr", ram_addr, 7'h00);
      chk("dec_data", ram_wdata, 8'h42);
      chk("dec_wrap", cursor, 7'h7F);
      nib(1'b0, 4'h0);
      nib(1'b0, 4'h6);
      nib(1'b1, 4'h4);
      nib(1'b1, 4'h3);
      chk("inc_addr", ram_addr, 7'h7F);
      chk("inc_wrap", cursor, 7'h00);
      // RS mismatch between nibbles
      doReset();
      nib(1'b0, 4'h2);
      waitIdle();
      nib(1'b1, 4'h4);
      chk("rsm_pre_err", err_timing, 0);
      nib(1'b0, 4'h1);
      chk("rsm_data", byte_data, 8'h41);
      chk("rsm_rs", byte_rs, 1);
      chk("rsm_err", err_timing, 1);
      // strobe during busy
      doReset();
      chk("rst_err_clr", err_timing, 0);
      nib(1'b0, 4'h2);
      chk("first_noerr", err_timing, 0);
      waitIdle();
      nib(1'b0, 4'h0);
      nib(1'b0, 4'hC);
      chk("c_noerr", err_timing, 0);
      repeat (10) @(negedge CLK);
      nib(1'b0, 4'h0);
      chk("busy_err", err_timing, 1);
      nib(1'b0, 4'hC);
      chk("busy_err_valid", byte_valid, 1);
      waitIdle();
      nib(1'b0, 4'h0);
      nib(1'b0, 4'hC);
      chk("err_sticky", err_timing, 1);
      doReset();
      nib(1'b0, 4'h2);
      waitIdle();
      nib(1'b0, 4'h0);
      nib(1'b0, 4'hC);
      chk("idle_noerr", err_timing, 0);
      // reset mid-byte
      waitIdle();
      nib(1'b0, 4'h8);
      doReset();
      chk("mid_mode4", mode4, 0);
      nib(1'b0, 4'h3);
      chk("mid_valid", byte_valid, 1);
      chk("mid_data", byte_data, 8'h30);
      chk("mid_stay_if8", mode4, 0);
`ifdef LCD_RX_LINEBUF_EN
      doReset();
      nib(1'b0, 4'h2);
      waitIdle();
      nib(1'b0, 4'hC);
      nib(1'b0, 4'h1);
      waitIdle();
      nib(1'b1, 4'h4);
      nib(1'b1, 4'h1);
      chk("lb_addr", ram_addr, 7'h41);
      @(negedge CLK);
      rd_line = 1'b1;
      rd_col  = 4'h1;
      @(negedge CLK);
      chk("lb_char", rd_char, 8'h41);
      rd_col = 4'h2;
      @(negedge CLK);
      chk("lb_blank", rd_char, 8'h20);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
